// File: rtl/icape2_wr_ctrl.sv
// icape2_wr_ctrl: buffers assembled 32-bit configuration words in a small FIFO
// and drains them into the Artix-7 ICAPE2 write port. Each burst is framed by
// a one-cycle LEAD (RDWRB low, CSIB high) and a one-cycle TAIL, so RDWRB only
// ever changes while CSIB is high. Data is bit-mirrored within each byte.
module icape2_wr_ctrl #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      word_in,
    input  logic             word_valid,
    output logic             icap_csib,
    output logic             icap_rdwrb,
    output logic [31:0]      icap_din,
    output logic             busy,
    output logic             overflow,
    output logic [CNT_W-1:0] word_count
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_V = FIFO_DEPTH[AW:0];
    localparam logic [AW:0] OCC_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        WRITE = 2'd2,
        TAIL  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [31:0]      fifoMem [FIFO_DEPTH];
    logic [AW-1:0]    wrPtr_q;
    logic [AW-1:0]    rdPtr_q;
    logic [AW:0]      occ_q;
    logic [AW:0]      occ_d;

    logic             csib_q;
    logic             rdwrb_q;
    logic [31:0]      din_q;
    logic             busy_q;
    logic             overflow_q;
    logic [CNT_W-1:0] count_q;

    logic fifoFull;
    logic fifoEmpty;
    logic doPush;
    logic doPop;

    // ICAPE2 expects each byte bit-reversed relative to the usual bitstream order.
    function automatic logic [31:0] swapBits(input logic [31:0] w);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 8; i++) begin
                r[8*k+i] = w[8*k+7-i];
            end
        end
        return r;
    endfunction

    assign fifoFull  = (occ_q == DEPTH_V);
    assign fifoEmpty = (occ_q == '0);
    // A push while full is refused even if a pop frees a slot this same cycle.
    assign doPush    = word_valid && !fifoFull;
    assign doPop     = ((state_q == LEAD) || (state_q == WRITE)) && !fifoEmpty;

    // Next occupancy: simultaneous push and pop leaves it unchanged.
    always_comb begin
        occ_d = occ_q;
        if (doPush && !doPop) begin
            occ_d = occ_q + OCC_ONE;
        end else if (!doPush && doPop) begin
            occ_d = occ_q - OCC_ONE;
        end
    end

    // Burst sequencing: a burst always opens with LEAD and closes with TAIL.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifoEmpty) state_d = LEAD;
            LEAD:    state_d = WRITE;
            WRITE:   if (fifoEmpty) state_d = TAIL;
            TAIL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FIFO storage; needs no reset because the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (doPush) begin
            fifoMem[wrPtr_q] <= word_in;
        end
    end

    // FIFO pointers, occupancy and the sticky drop flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            occ_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            occ_q <= occ_d;
            if (word_valid && fifoFull) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // FSM with registered ICAP outputs derived from the state being entered,
    // so RDWRB falls with LEAD and rises only when returning to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            csib_q  <= 1'b1;
            rdwrb_q <= 1'b1;
            din_q   <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rdwrb_q <= (state_d == IDLE);
            csib_q  <= !doPop;
            busy_q  <= (state_d != IDLE) || (occ_d != '0);
            if (doPop) begin
                din_q   <= swapBits(fifoMem[rdPtr_q]);
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign icap_csib  = csib_q;
    assign icap_rdwrb = rdwrb_q;
    assign icap_din   = din_q;
    assign busy       = busy_q;
    assign overflow   = overflow_q;
    assign word_count = count_q;

endmodule

// File: tb/tb_icape2_wr_ctrl.sv
// tb_icape2_wr_ctrl: directed bench for icape2_wr_ctrl. dut1 uses the default
// sizing; dut2 uses a 2-entry FIFO and a 4-bit counter so overflow and counter
// wrap can be reached in a few hundred cycles.
module tb_icape2_wr_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [31:0] wordIn1 = '0;
    logic        wordValid1 = 1'b0;
    logic        csib1, rdwrb1, busy1, overflow1;
    logic [31:0] din1;
    logic [15:0] count1;

    logic [31:0] wordIn2 = '0;
    logic        wordValid2 = 1'b0;
    logic        csib2, rdwrb2, busy2, overflow2;
    logic [31:0] din2;
    logic [3:0]  count2;

    int checks = 0;
    int failures = 0;

    logic [31:0] obs1[$];
    logic [31:0] obs2[$];
    int lows1 = 0;
    int bursts1 = 0;
    int leads1 = 0;
    int viol1 = 0;
    logic prevCsib1 = 1'b1;
    logic prevRdwrb1 = 1'b1;

    icape2_wr_ctrl #(.FIFO_DEPTH(8), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .word_in(wordIn1), .word_valid(wordValid1),
        .icap_csib(csib1), .icap_rdwrb(rdwrb1), .icap_din(din1),
        .busy(busy1), .overflow(overflow1), .word_count(count1)
    );

    icape2_wr_ctrl #(.FIFO_DEPTH(2), .CNT_W(4)) dut2 (
        .clk(clk), .rst(rst), .word_in(wordIn2), .word_valid(wordValid2),
        .icap_csib(csib2), .icap_rdwrb(rdwrb2), .icap_din(din2),
        .busy(busy2), .overflow(overflow2), .word_count(count2)
    );

    always #5 clk = ~clk;

    // Watch the ICAP ports away from the active edge: log written words and
    // flag any CSIB/RDWRB sequencing violation.
    always @(negedge clk) begin
        if (rst) begin
            prevCsib1  = 1'b1;
            prevRdwrb1 = 1'b1;
        end else begin
            if (!csib1) begin
                obs1.push_back(din1);
                lows1++;
            end
            if (!csib2) obs2.push_back(din2);
            if (!csib1 && rdwrb1) viol1++;
            if ((rdwrb1 != prevRdwrb1) && !(csib1 && prevCsib1)) viol1++;
            if (prevCsib1 && !csib1) bursts1++;
            if (prevRdwrb1 && !rdwrb1) leads1++;
            prevCsib1  = csib1;
            prevRdwrb1 = rdwrb1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Present one word to the selected DUT for the next rising edge.
    task automatic applyStimulus(input bit sel, input logic [31:0] w);
        @(negedge clk);
        if (sel) begin
            wordIn2 = w;
            wordValid2 = 1'b1;
        end else begin
            wordIn1 = w;
            wordValid1 = 1'b1;
        end
    endtask

    task automatic idleCycles(input int n);
        @(negedge clk);
        wordValid1 = 1'b0;
        wordValid2 = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    logic [31:0] expA[10];
    logic [31:0] inA[10];
    int s0, s1, s2, s3;
    bit seenLow;

    initial begin
        // Bytes A5 are bit palindromes; low bytes 1..10 reversed by hand.
        expA = '{32'hA5A5A580, 32'hA5A5A540, 32'hA5A5A5C0, 32'hA5A5A520, 32'hA5A5A5A0,
                 32'hA5A5A560, 32'hA5A5A5E0, 32'hA5A5A510, 32'hA5A5A590, 32'hA5A5A550};
        for (int i = 0; i < 10; i++) inA[i] = {24'hA5A5A5, 8'(i + 1)};

        // Reset state.
        repeat (3) @(negedge clk);
        checkOutput("rst_csib", 32'(csib1), 32'd1);
        checkOutput("rst_rdwrb", 32'(rdwrb1), 32'd1);
        checkOutput("rst_din", din1, 32'h0);
        checkOutput("rst_busy", 32'(busy1), 32'd0);
        checkOutput("rst_ovf", 32'(overflow1), 32'd0);
        checkOutput("rst_count", 32'(count1), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single word: latency and framing edge by edge.
        applyStimulus(1'b0, 32'hAA995566);
        @(negedge clk); wordValid1 = 1'b0;
        checkOutput("lat_t0_busy", 32'(busy1), 32'd1);
        checkOutput("lat_t0_rdwrb", 32'(rdwrb1), 32'd1);
        @(negedge clk);
        checkOutput("lat_t1_rdwrb", 32'(rdwrb1), 32'd0);
        checkOutput("lat_t1_csib", 32'(csib1), 32'd1);
        @(negedge clk);
        checkOutput("lat_t2_csib", 32'(csib1), 32'd0);
        checkOutput("lat_t2_din", din1, 32'h5599AA66);
        checkOutput("lat_t2_count", 32'(count1), 32'd1);
        @(negedge clk);
        checkOutput("lat_t3_csib", 32'(csib1), 32'd1);
        checkOutput("lat_t3_rdwrb", 32'(rdwrb1), 32'd0);
        checkOutput("lat_t3_din_hold", din1, 32'h5599AA66);
        @(negedge clk);
        checkOutput("lat_t4_rdwrb", 32'(rdwrb1), 32'd1);
        checkOutput("lat_t4_busy", 32'(busy1), 32'd0);
        repeat (3) @(negedge clk);

        // Sync sequence back to back: one burst of three writes.
        obs1.delete();
        s0 = lows1; s1 = bursts1; s2 = leads1;
        applyStimulus(1'b0, 32'hFFFFFFFF);
        applyStimulus(1'b0, 32'hAA995566);
        applyStimulus(1'b0, 32'h20000000);
        idleCycles(12);
        checkOutput("sync_nwords", 32'(obs1.size()), 32'd3);
        if (obs1.size() == 3) begin
            checkOutput("sync_w0", obs1[0], 32'hFFFFFFFF);
            checkOutput("sync_w1", obs1[1], 32'h5599AA66);
            checkOutput("sync_w2", obs1[2], 32'h04000000);
        end
        checkOutput("sync_lows", 32'(lows1 - s0), 32'd3);
        checkOutput("sync_bursts", 32'(bursts1 - s1), 32'd1);
        checkOutput("sync_leads", 32'(leads1 - s2), 32'd1);
        checkOutput("sync_count", 32'(count1), 32'd4);

        // UART-rate spacing: four separate single-word bursts.
        obs1.delete();
        s0 = lows1; s1 = bursts1; s2 = leads1;
        applyStimulus(1'b0, 32'h01020408); idleCycles(40);
        applyStimulus(1'b0, 32'h0F0F0F0F); idleCycles(40);
        applyStimulus(1'b0, 32'h12345678); idleCycles(40);
        applyStimulus(1'b0, 32'h00000001); idleCycles(40);
        checkOutput("spaced_nwords", 32'(obs1.size()), 32'd4);
        if (obs1.size() == 4) begin
            checkOutput("spaced_w0", obs1[0], 32'h80402010);
            checkOutput("spaced_w1", obs1[1], 32'hF0F0F0F0);
            checkOutput("spaced_w2", obs1[2], 32'h482C6A1E);
            checkOutput("spaced_w3", obs1[3], 32'h00000080);
        end
        checkOutput("spaced_lows", 32'(lows1 - s0), 32'd4);
        checkOutput("spaced_bursts", 32'(bursts1 - s1), 32'd4);
        checkOutput("spaced_leads", 32'(leads1 - s2), 32'd4);
        checkOutput("spaced_count", 32'(count1), 32'd8);

        // Ten words back to back on the 8-deep FIFO: all delivered, no drop.
        obs1.delete();
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, inA[i]);
        idleCycles(20);
        checkOutput("b10_nwords", 32'(obs1.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < obs1.size()) checkOutput($sformatf("b10_w%0d", i), obs1[i], expA[i]);
        end
        checkOutput("b10_ovf", 32'(overflow1), 32'd0);
        checkOutput("b10_count", 32'(count1), 32'd18);

        // 2-deep FIFO: third word arrives while full and a pop happens -> dropped.
        obs2.delete();
        applyStimulus(1'b1, 32'h11111111);
        applyStimulus(1'b1, 32'h22222222);
        applyStimulus(1'b1, 32'h33333333);
        applyStimulus(1'b1, 32'h44444444);
        idleCycles(12);
        checkOutput("ovf_nwords", 32'(obs2.size()), 32'd3);
        if (obs2.size() == 3) begin
            checkOutput("ovf_w0", obs2[0], 32'h88888888);
            checkOutput("ovf_w1", obs2[1], 32'h44444444);
            checkOutput("ovf_w2", obs2[2], 32'h22222222);
        end
        checkOutput("ovf_flag", 32'(overflow2), 32'd1);
        checkOutput("ovf_count", 32'(count2), 32'd3);
        idleCycles(10);
        checkOutput("ovf_sticky", 32'(overflow2), 32'd1);

        // Reset asserted in the middle of a five-word burst.
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, inA[i]);
        @(negedge clk); wordValid1 = 1'b0;
        seenLow = 1'b0;
        for (int i = 0; i < 20 && !seenLow; i++) begin
            if (!csib1) seenLow = 1'b1;
            else @(negedge clk);
        end
        checkOutput("mid_saw_low", 32'(seenLow), 32'd1);
        @(posedge clk); #2;
        checkOutput("mid_pre_csib", 32'(csib1), 32'd0);
        rst = 1'b1;
        #1;
        checkOutput("mid_csib", 32'(csib1), 32'd1);
        checkOutput("mid_rdwrb", 32'(rdwrb1), 32'd1);
        checkOutput("mid_din", din1, 32'h0);
        checkOutput("mid_count", 32'(count1), 32'd0);
        checkOutput("mid_ovf2", 32'(overflow2), 32'd0);
        checkOutput("mid_busy", 32'(busy1), 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        s0 = lows1;
        repeat (15) @(negedge clk);
        checkOutput("mid_no_writes", 32'(lows1 - s0), 32'd0);
        checkOutput("mid_busy_after", 32'(busy1), 32'd0);

        // 4-bit counter wraps: 17 words spaced apart leave a count of 1.
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b1, 32'(i));
            idleCycles(6);
        end
        idleCycles(10);
        checkOutput("wrap_count", 32'(count2), 32'd1);
        checkOutput("wrap_ovf", 32'(overflow2), 32'd0);

        checkOutput("proto_viol", 32'(viol1), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
